// File: rtl/ttl_interval_ctrl.sv
// Control FSM for a cascaded 74161 counter chain forming a programmable interval timer.
// Drives load/enable/reload value into the chain and turns its ripple-carry into Tick/Overrun flags.
module ttl_interval_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Clear,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Periodic,
    input  logic [WIDTH-1:0] Period,
    input  logic             RCO,
    input  logic             Tick_ack,
    output logic             Ctr_clear_bar,
    output logic             Load_bar,
    output logic             ENT,
    output logic             ENP,
    output logic [WIDTH-1:0] D,
    output logic             Busy,
    output logic             Tick,
    output logic             Overrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] per_q, per_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             overrun_q, overrun_d;
    logic             terminal_s;

    // Next-state, latched configuration and sticky flag logic
    always_comb begin
        state_d    = state_q;
        per_d      = per_q;
        mode_d     = mode_q;
        tick_d     = tick_q;
        overrun_d  = overrun_q;
        terminal_s = (state_q == ST_RUN) && RCO;

        case (state_q)
            ST_IDLE: begin
                if (Start && !Stop) begin
                    per_d   = Period;
                    mode_d  = Periodic;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (Stop) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (Stop) begin
                    state_d = ST_IDLE;
                end else if (terminal_s && !mode_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An ack coinciding with a completion loses to it, without flagging overrun
        if (terminal_s) begin
            tick_d = 1'b1;
            if (tick_q && !Tick_ack) begin
                overrun_d = 1'b1;
            end else begin
                overrun_d = overrun_q;
            end
        end else if (Tick_ack) begin
            tick_d = 1'b0;
        end else begin
            tick_d = tick_q;
        end

        // Reload value tracks the next period so it is ready during the LOAD cycle
        d_d = {WIDTH{1'b0}} - per_d;
    end

    // State and configuration registers with synchronous clear
    always_ff @(posedge Clk) begin
        if (Clear) begin
            state_q   <= ST_IDLE;
            per_q     <= {WIDTH{1'b0}};
            d_q       <= {WIDTH{1'b0}};
            mode_q    <= 1'b0;
            tick_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_q     <= per_d;
            d_q       <= d_d;
            mode_q    <= mode_d;
            tick_q    <= tick_d;
            overrun_q <= overrun_d;
        end
    end

    // Chain controls; the periodic reload path is combinational from RCO so intervals abut
    always_comb begin
        Ctr_clear_bar = ~Clear;
        Load_bar      = ~((state_q == ST_LOAD) ||
                          ((state_q == ST_RUN) && RCO && mode_q && !Stop));
        ENT           = (state_q == ST_RUN);
        ENP           = (state_q == ST_RUN);
        D             = d_q;
        Busy          = (state_q != ST_IDLE);
        Tick          = tick_q;
        Overrun       = overrun_q;
    end

endmodule

// File: tb/tb_ttl_interval_ctrl.sv
// Bench: controller plus a behavioural two-stage 74161 chain; directed vector table,
// corner-case sequences, then random stimulus against an interval-level reference model.
module tb_ttl_interval_ctrl;

    logic       Clk = 1'b0;
    logic       Clear, Start, Stop, Periodic, Tick_ack;
    logic [7:0] Period;
    logic       RCO;
    logic       Ctr_clear_bar, Load_bar, ENT, ENP, Busy, Tick, Overrun;
    logic [7:0] D;
    logic [7:0] q;

    int errors = 0;
    int checks = 0;

    ttl_interval_ctrl #(.WIDTH(8)) dut (
        .Clk(Clk), .Clear(Clear), .Start(Start), .Stop(Stop), .Periodic(Periodic),
        .Period(Period), .RCO(RCO), .Tick_ack(Tick_ack), .Ctr_clear_bar(Ctr_clear_bar),
        .Load_bar(Load_bar), .ENT(ENT), .ENP(ENP), .D(D), .Busy(Busy), .Tick(Tick),
        .Overrun(Overrun)
    );

    always #5 Clk = ~Clk;

    // Two cascaded 74161s: upper ENT is lower RCO, so chain RCO = ENT & all-ones
    always @(posedge Clk) begin
        if (!Ctr_clear_bar) q <= 8'h00;
        else if (!Load_bar) q <= D;
        else if (ENT && ENP) q <= q + 8'h01;
    end
    assign RCO = ENT & (&q);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic       clr, st, sp, pe;
        logic [7:0] per;
        logic       ack;
        logic [7:0] q, d;
        logic       busy, tick, ovr, lb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic clr, logic st, logic sp, logic pe, logic [7:0] per,
                                logic ack, logic [7:0] eq, logic [7:0] ed, logic busy,
                                logic tick, logic ovr, logic lb);
        vec_t v;
        v.clr = clr; v.st = st; v.sp = sp; v.pe = pe; v.per = per; v.ack = ack;
        v.q = eq; v.d = ed; v.busy = busy; v.tick = tick; v.ovr = ovr; v.lb = lb;
        return v;
    endfunction

    task automatic drive(logic clr, logic st, logic sp, logic pe, logic [7:0] per, logic ack);
        Clear = clr; Start = st; Stop = sp; Periodic = pe; Period = per; Tick_ack = ack;
    endtask

    // Reference model state: phase 0 idle, 1 load, 2 run; rem = clocks left in interval
    int mphase, mrem, mmode, mper, mtick, mov, mq, md;

    task automatic model_reset();
        mphase = 0; mrem = 0; mmode = 0; mper = 0; mtick = 0; mov = 0; mq = 0; md = 0;
    endtask

    task automatic model_check(int cyc);
        logic exp_lb;
        exp_lb = !(mphase == 1 || (mphase == 2 && mrem == 1 && mmode == 1 && !Stop));
        chk($sformatf("rnd%0d.busy", cyc), Busy, (mphase != 0));
        chk($sformatf("rnd%0d.ent", cyc), {ENT, ENP}, (mphase == 2) ? 2'b11 : 2'b00);
        chk($sformatf("rnd%0d.d", cyc), D, md);
        chk($sformatf("rnd%0d.q", cyc), q, mq);
        chk($sformatf("rnd%0d.tick", cyc), Tick, mtick);
        chk($sformatf("rnd%0d.ovr", cyc), Overrun, mov);
        chk($sformatf("rnd%0d.lb", cyc), Load_bar, exp_lb);
        chk($sformatf("rnd%0d.ccb", cyc), Ctr_clear_bar, !Clear);
    endtask

    task automatic model_step();
        int term;
        if (Clear) begin
            model_reset();
        end else begin
            term = (mphase == 2 && mrem == 1);
            if (term) begin
                if (mtick == 1 && !Tick_ack) mov = 1;
                mtick = 1;
            end else if (Tick_ack) begin
                mtick = 0;
            end
            case (mphase)
                0: if (Start && !Stop) begin
                    mper = Period; mmode = Periodic; md = (256 - Period) % 256; mphase = 1;
                end
                1: begin
                    mq = md; mrem = (mper == 0) ? 256 : mper; mphase = Stop ? 0 : 2;
                end
                default: begin
                    if (term && mmode == 1 && !Stop) begin
                        mq = md; mrem = (mper == 0) ? 256 : mper;
                    end else begin
                        mq = (mq + 1) % 256; mrem--;
                        if (Stop || term) mphase = 0;
                    end
                end
            endcase
        end
    endtask

    initial begin
        int k;
        logic [7:0] frozen;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst.lb", Load_bar, 1'b1);
        chk("rst.ent", {ENT, ENP}, 2'b00);
        chk("rst.busy", Busy, 1'b0);
        chk("rst.tick", {Tick, Overrun}, 2'b00);
        chk("rst.q", q, 8'h00);
        chk("rst.d", D, 8'h00);
        chk("rst.ccb", Ctr_clear_bar, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge Clk);

        // One-shot N=5, ack, periodic N=3 without ack, then clear and ack/stop cases
        vecs.push_back(mk(0, 1, 0, 0, 8'd5, 0, 8'h00, 8'hFB, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'd5, 0, 8'hFB, 8'hFB, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 8'd5, 0, 8'hFC, 8'hFB, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 8'd5, 0, 8'hFD, 8'hFB, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 8'd5, 0, 8'hFE, 8'hFB, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 8'd5, 0, 8'hFF, 8'hFB, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 8'd5, 0, 8'h00, 8'hFB, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 8'd5, 0, 8'h00, 8'hFB, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 8'd5, 1, 8'h00, 8'hFB, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 8'd3, 0, 8'h00, 8'hFD, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8'd3, 0, 8'hFD, 8'hFD, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 8'd3, 0, 8'hFE, 8'hFD, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 8'd3, 0, 8'hFF, 8'hFD, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8'd3, 0, 8'hFD, 8'hFD, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 8'd3, 0, 8'hFE, 8'hFD, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 8'd3, 0, 8'hFF, 8'hFD, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8'd3, 0, 8'hFD, 8'hFD, 1, 1, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 8'd3, 0, 8'h00, 8'h00, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 8'd3, 0, 8'h00, 8'hFD, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8'd3, 0, 8'hFD, 8'hFD, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 8'd3, 0, 8'hFE, 8'hFD, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 8'd3, 0, 8'hFF, 8'hFD, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8'd3, 0, 8'hFD, 8'hFD, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 8'd3, 0, 8'hFE, 8'hFD, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 8'd3, 0, 8'hFF, 8'hFD, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8'd3, 1, 8'hFD, 8'hFD, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 8'd3, 1, 8'hFE, 8'hFD, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 8'd3, 0, 8'hFF, 8'hFD, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 8'd7, 0, 8'hFF, 8'hFD, 0, 0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].clr, vecs[i].st, vecs[i].sp, vecs[i].pe, vecs[i].per, vecs[i].ack);
            @(posedge Clk);
            @(negedge Clk);
            chk($sformatf("vec%0d.q", i), q, vecs[i].q);
            chk($sformatf("vec%0d.d", i), D, vecs[i].d);
            chk($sformatf("vec%0d.busy", i), Busy, vecs[i].busy);
            chk($sformatf("vec%0d.tick", i), Tick, vecs[i].tick);
            chk($sformatf("vec%0d.ovr", i), Overrun, vecs[i].ovr);
            chk($sformatf("vec%0d.lb", i), Load_bar, vecs[i].lb);
            chk($sformatf("vec%0d.ccb", i), Ctr_clear_bar, !vecs[i].clr);
        end

        // Period=0 one-shot: full 256-state interval, Tick on the 257th edge after Start
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        @(posedge Clk);
        @(negedge Clk);
        chk("p0.d", D, 8'h00);
        chk("p0.lb", Load_bar, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        k = 1;
        @(posedge Clk);
        @(negedge Clk);
        while (!Tick && k < 400) begin
            @(posedge Clk);
            @(negedge Clk);
            k++;
        end
        chk("p0.edges", k, 257);
        chk("p0.busy", Busy, 1'b0);
        chk("p0.q", q, 8'h00);

        // Stop in RUN with Q=0x80: the chain takes that final count, then freezes
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
        @(posedge Clk);
        @(negedge Clk);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        k = 0;
        while (q != 8'h80 && k < 300) begin
            @(posedge Clk);
            @(negedge Clk);
            k++;
        end
        chk("stop.reach80", (q == 8'h80), 1'b1);
        Stop = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Stop = 1'b0;
        chk("stop.busy", Busy, 1'b0);
        chk("stop.ent", {ENT, ENP}, 2'b00);
        chk("stop.q", q, 8'h81);
        frozen = q;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("stop.frozen", q, frozen);
        chk("stop.tick", Tick, 1'b0);

        // Clear in the middle of a periodic run
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'd10, 1'b0);
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        chk("clr.busy_before", Busy, 1'b1);
        Clear = 1'b1;
        #1;
        chk("clr.ccb", Ctr_clear_bar, 1'b0);
        @(posedge Clk);
        @(negedge Clk);
        chk("clr.busy", Busy, 1'b0);
        chk("clr.q", q, 8'h00);
        chk("clr.d", D, 8'h00);
        chk("clr.lb", Load_bar, 1'b1);
        chk("clr.ent", {ENT, ENP}, 2'b00);

        // Random stimulus against the reference model (starts from the clear just applied)
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            Clear    = ($urandom_range(0, 199) == 0);
            Start    = ($urandom_range(0, 3) == 0);
            Stop     = ($urandom_range(0, 29) == 0);
            Periodic = $urandom_range(0, 1);
            Period   = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(1, 6));
            Tick_ack = ($urandom_range(0, 4) == 0);
            #1;
            model_check(c);
            model_step();
            @(posedge Clk);
            @(negedge Clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
